c3_heap_unit: RTL

Parametrised priority-queue custom-instruction unit for the C3 coprocessor slot: a true binary heap (min or max) with push, pop, peek, replace-top and clear, a valid/ready input handshake, and register/tag passthrough to writeback. It is the next generation of the C3 heap instruction. Ordering is restored by a multi-cycle sift-up/sift-down FSM instead of a shift, so the unit reports full/empty and illegal-op status.

---
 rtl/c3_heap_pkg.sv | 25 ++
 rtl/c3_heap_cmp.sv | 34 +++
 rtl/c3_heap_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/c3_heap_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | c3_heap_pkg : opcodes, status codes and FSM states for c3_heap_unit   |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
package c3_heap_pkg;
  localparam logic [2:0] OP_PUSH    = 3'b000;
  localparam logic [2:0] OP_POP     = 3'b001;
  localparam logic [2:0] OP_PEEK    = 3'b010;
  localparam logic [2:0] OP_CLEAR   = 3'b011;
  localparam logic [2:0] OP_REPLACE = 3'b100;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_EMPTY   = 2'b01;
  localparam logic [1:0] ST_FULL    = 2'b10;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SIFT_UP = 2'd1,
    S_SIFT_DN = 2'd2,
    S_RESP    = 2'd3
  } heap_state_e;
endpackage
`default_nettype wire

// File: rtl/c3_heap_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | c3_heap_cmp : heap ordering compare and sift-down child selection     |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module c3_heap_cmp #(
  parameter int DATA_W   = 32,
  parameter bit MIN_HEAP = 1'b1
) (
  input  logic [DATA_W-1:0] i_cur,
  input  logic [DATA_W-1:0] i_parent,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  input  logic              i_left_ok,
  input  logic              i_right_ok,
  output logic              o_up_swap,
  output logic              o_dn_swap,
  output logic              o_pick_r
);
  function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return MIN_HEAP ? (a < b) : (a > b);
  endfunction

  logic [DATA_W-1:0] w_best;

  always_comb begin
    // Strict compare: on equal children the left one wins.
    o_pick_r  = i_right_ok && better(i_right, i_left);
    w_best    = o_pick_r ? i_right : i_left;
    o_dn_swap = i_left_ok && better(w_best, i_cur);
    o_up_swap = better(i_cur, i_parent);
  end
endmodule
`default_nettype wire

// File: rtl/c3_heap_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | c3_heap_unit : binary-heap priority queue custom instruction (C3)     |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module c3_heap_unit
  import c3_heap_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int CNT_W    = $clog2(DEPTH) + 1,
  parameter bit MIN_HEAP = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_v,
  output logic              in_ready,
  input  logic [4:0]        rd,
  input  logic [2:0]        vrd1,
  input  logic [2:0]        vrd2,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_v,
  output logic [4:0]        out_rd,
  output logic [2:0]        out_vrd1,
  output logic [2:0]        out_vrd2,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_status,
  output logic [CNT_W-1:0]  out_count
);
  localparam int               c_aw    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  heap_state_e       r_state;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_idx;
  logic [4:0]        r_rd;
  logic [2:0]        r_vrd1;
  logic [2:0]        r_vrd2;
  logic [DATA_W-1:0] r_data;

  logic              w_accept, w_full, w_empty;
  logic              w_go_up, w_go_dn;
  logic [1:0]        w_dir_status;
  logic [DATA_W-1:0] w_dir_data;
  logic [CNT_W-1:0]  w_next_count;
  logic [CNT_W-1:0]  w_parent, w_child;
  logic [CNT_W:0]    w_left, w_right;
  logic              w_left_ok, w_right_ok;
  logic [c_aw-1:0]   w_idx_a, w_parent_a, w_left_a, w_right_a, w_child_a, w_cnt_a, w_last_a;
  logic              w_up_swap, w_dn_swap, w_pick_r;
  logic              w_do_up, w_do_dn, w_sift_done;

  assign in_ready = (r_state == S_IDLE) || (r_state == S_RESP);
  assign w_accept = in_v && in_ready;
  assign w_full   = (r_count == c_depth);
  assign w_empty  = (r_count == '0);

  // Child indices carry one extra bit so 2*idx+2 never wraps below count.
  assign w_parent   = (r_idx - 1'b1) >> 1;
  assign w_left     = {r_idx, 1'b1};
  assign w_right    = w_left + 1'b1;
  assign w_left_ok  = w_left < {1'b0, r_count};
  assign w_right_ok = w_right < {1'b0, r_count};
  assign w_child    = CNT_W'(w_pick_r ? w_right : w_left);

  assign w_idx_a    = c_aw'(r_idx);
  assign w_parent_a = c_aw'(w_parent);
  assign w_left_a   = c_aw'(w_left);
  assign w_right_a  = c_aw'(w_right);
  assign w_child_a  = c_aw'(w_child);
  assign w_cnt_a    = c_aw'(r_count);
  assign w_last_a   = c_aw'(r_count - 1'b1);

  c3_heap_cmp #(
    .DATA_W   (DATA_W),
    .MIN_HEAP (MIN_HEAP)
  ) u_cmp (
    .i_cur      (r_mem[w_idx_a]),
    .i_parent   (r_mem[w_parent_a]),
    .i_left     (r_mem[w_left_a]),
    .i_right    (r_mem[w_right_a]),
    .i_left_ok  (w_left_ok),
    .i_right_ok (w_right_ok),
    .o_up_swap  (w_up_swap),
    .o_dn_swap  (w_dn_swap),
    .o_pick_r   (w_pick_r)
  );

  assign w_do_up     = (r_state == S_SIFT_UP) && (r_idx != '0) && w_up_swap;
  assign w_do_dn     = (r_state == S_SIFT_DN) && w_dn_swap;
  assign w_sift_done = ((r_state == S_SIFT_UP) && !w_do_up) ||
                       ((r_state == S_SIFT_DN) && !w_do_dn);

  always_comb begin
    w_go_up      = 1'b0;
    w_go_dn      = 1'b0;
    w_dir_status = ST_OK;
    w_dir_data   = '0;
    w_next_count = r_count;
    case (vrd1)
      OP_PUSH: begin
        if (w_full) w_dir_status = ST_FULL;
        else begin
          w_go_up      = 1'b1;
          w_next_count = r_count + 1'b1;
        end
      end
      OP_POP: begin
        if (w_empty) w_dir_status = ST_EMPTY;
        else begin
          w_go_dn      = 1'b1;
          w_next_count = r_count - 1'b1;
        end
      end
      OP_PEEK: begin
        if (w_empty) w_dir_status = ST_EMPTY;
        else         w_dir_data   = r_mem[0];
      end
      OP_CLEAR:   w_next_count = '0;
      OP_REPLACE: begin
        if (w_empty) w_dir_status = ST_EMPTY;
        else         w_go_dn      = 1'b1;
      end
      default:    w_dir_status = ST_ILLEGAL;
    endcase
  end

  // Heap storage is deliberately unreset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (w_accept && w_go_up) r_mem[w_cnt_a] <= in_data;
    if (w_accept && w_go_dn) r_mem[0] <= (vrd1 == OP_POP) ? r_mem[w_last_a] : in_data;
    if (w_do_up) begin
      r_mem[w_idx_a]    <= r_mem[w_parent_a];
      r_mem[w_parent_a] <= r_mem[w_idx_a];
    end
    if (w_do_dn) begin
      r_mem[w_idx_a]   <= r_mem[w_child_a];
      r_mem[w_child_a] <= r_mem[w_idx_a];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_idx      <= '0;
      r_rd       <= '0;
      r_vrd1     <= '0;
      r_vrd2     <= '0;
      r_data     <= '0;
      out_v      <= 1'b0;
      out_rd     <= '0;
      out_vrd1   <= '0;
      out_vrd2   <= '0;
      out_data   <= '0;
      out_status <= ST_OK;
      out_count  <= '0;
    end else begin
      out_v <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          r_state <= S_IDLE;
          if (w_accept) begin
            r_rd    <= rd;
            r_vrd1  <= vrd1;
            r_vrd2  <= vrd2;
            r_count <= w_next_count;
            r_data  <= w_go_dn ? r_mem[0] : '0;
            if (w_go_up) begin
              r_idx   <= r_count;
              r_state <= S_SIFT_UP;
            end else if (w_go_dn) begin
              r_idx   <= '0;
              r_state <= S_SIFT_DN;
            end else begin
              r_state    <= S_RESP;
              out_v      <= 1'b1;
              out_rd     <= rd;
              out_vrd1   <= vrd1;
              out_vrd2   <= vrd2;
              out_data   <= w_dir_data;
              out_status <= w_dir_status;
              out_count  <= w_next_count;
            end
          end
        end
        S_SIFT_UP: if (w_do_up) r_idx <= w_parent;
        S_SIFT_DN: if (w_do_dn) r_idx <= w_child;
        default:   r_state <= S_IDLE;
      endcase
      if (w_sift_done) begin
        r_state    <= S_RESP;
        out_v      <= 1'b1;
        out_rd     <= r_rd;
        out_vrd1   <= r_vrd1;
        out_vrd2   <= r_vrd2;
        out_data   <= r_data;
        out_status <= ST_OK;
        out_count  <= r_count;
      end
    end
  end
endmodule
`default_nettype wire
